// File: rtl/sub_pkg.sv
// Shared constants and state encoding for the nibble-serial subtract sequencer.
package sub_pkg;

  // Width of the shared subtractor slice; operands are processed this many bits per clock.
  localparam int SLICE_W = 4;

  // Sequencer states: waiting for a request, walking the slices, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_slice4.sv
// Combinational 4-bit ripple subtractor: d = a - b - bi, with borrow-out and signed overflow.
module sub_slice4
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bi,
  output logic [SLICE_W-1:0] d,
  output logic               bo,
  output logic               ovf
);

  // Ripple the borrow from bit 0 upward; overflow compares borrow into and out of the top bit.
  always_comb begin
    logic brw;
    logic brw_top;
    d       = '0;
    bo      = 1'b0;
    ovf     = 1'b0;
    brw     = bi;
    brw_top = 1'b0;
    for (int i = 0; i < SLICE_W; i++) begin
      if (i == SLICE_W - 1) begin
        brw_top = brw;
      end
      d[i] = a[i] ^ b[i] ^ brw;
      brw  = (~a[i] & b[i]) | (~a[i] & brw) | (b[i] & brw);
    end
    bo  = brw;
    ovf = brw_top ^ brw;
  end

endmodule

// File: rtl/sub_seq_ctrl.sv
// Multi-cycle WIDTH-bit subtractor: one shared 4-bit slice, one nibble per clock, LSB first.
module sub_seq_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   xr;
  logic [WIDTH-1:0]   yr;
  logic [IDX_W-1:0]   idx;
  logic               brw;
  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W-1:0] sd;
  logic               sbo;
  logic               sovf;
  logic               last;

  assign last = (idx == LAST_IDX);

  // Nibble mux feeding the single shared slice from the latched operands.
  always_comb begin
    sa = xr[int'(idx) * SLICE_W +: SLICE_W];
    sb = yr[int'(idx) * SLICE_W +: SLICE_W];
  end

  sub_slice4 u_slice (
    .a   (sa),
    .b   (sb),
    .bi  (brw),
    .d   (sd),
    .bo  (sbo),
    .ovf (sovf)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start is only honoured in IDLE, DONE always lasts a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are decoded straight from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: latch operands on accept, then write one result nibble and carry the borrow per clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xr       <= '0;
      yr       <= '0;
      idx      <= '0;
      brw      <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xr       <= x;
            yr       <= y;
            idx      <= '0;
            brw      <= bin;
            diff     <= '0;
            bout     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          diff[int'(idx) * SLICE_W +: SLICE_W] <= sd;
          brw <= sbo;
          if (last) begin
            bout     <= sbo;
            overflow <= sovf;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed self-checking bench for sub_seq_ctrl (WIDTH=16 and WIDTH=4 instances).
module tb_sub_seq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
  logic        overflow;

  logic        start4;
  logic [3:0]  x4;
  logic [3:0]  y4;
  logic        bin4;
  logic        busy4;
  logic        done4;
  logic [3:0]  diff4;
  logic        bout4;
  logic        overflow4;

  int checks;
  int failures;

  sub_seq_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .x        (x),
    .y        (y),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  sub_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start4),
    .x        (x4),
    .y        (y4),
    .bin      (bin4),
    .busy     (busy4),
    .done     (done4),
    .diff     (diff4),
    .bout     (bout4),
    .overflow (overflow4)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one operation and wait (bounded) for done; operands are scrambled after the accept.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        output int edges, output int busyCnt);
    x = a;
    y = b;
    bin = bi;
    start = 1'b1;
    edges = 0;
    busyCnt = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      start = 1'b0;
      x = 16'($urandom);
      y = 16'($urandom);
      bin = 1'($urandom);
      if (busy) busyCnt++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    x = 16'h0;
    y = 16'h0;
    bin = 1'b0;
    start4 = 1'b0;
    x4 = 4'h0;
    y4 = 4'h0;
    bin4 = 1'b0;
    #2;
    checks++;
    if ({busy, done, diff, bout, overflow} !== 19'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b diff=%h bout=%b ovf=%b need all 0",
               busy, done, diff, bout, overflow);
    end
    checks++;
    if ({busy4, done4, diff4, bout4, overflow4} !== 7'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_w4 got %b need 0", {busy4, done4, diff4, bout4, overflow4});
    end
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got busy=%b done=%b need 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int edges;
    int busyCnt;
    run_op(16'h1234, 16'h0235, 1'b0, edges, busyCnt);
    checks++;
    if (edges !== 5) begin
      failures++;
      $display("[TB] FAIL basic_latency got %0d edges need 5", edges);
    end
    checks++;
    if (busyCnt !== 4) begin
      failures++;
      $display("[TB] FAIL basic_busy_cycles got %0d need 4", busyCnt);
    end
    checks++;
    if ({diff, bout, overflow} !== {16'h0FFF, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL basic_result got diff=%h bout=%b ovf=%b need 0fff 0 0", diff, bout, overflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || diff !== 16'h0FFF) begin
      failures++;
      $display("[TB] FAIL basic_hold got done=%b diff=%h need 0 0fff", done, diff);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va [4] = '{16'h0000, 16'h0005, 16'h8000, 16'h7FFF};
    logic [15:0] vb [4] = '{16'h0001, 16'h0005, 16'h0001, 16'hFFFF};
    logic        vi [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [17:0] ve [4] = '{{16'hFFFF, 2'b10}, {16'hFFFF, 2'b10},
                            {16'h7FFF, 2'b01}, {16'h8000, 2'b11}};
    int edges;
    int busyCnt;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      run_op(va[i], vb[i], vi[i], edges, busyCnt);
      checks++;
      if (edges !== 5 || {diff, bout, overflow} !== ve[i]) begin
        failures++;
        $display("[TB] FAIL vector_%0d got edges=%0d diff=%h bout=%b ovf=%b need 5 %h %b %b",
                 i, edges, diff, bout, overflow, ve[i][17:2], ve[i][1], ve[i][0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] curX, curY, latX, latY;
    logic        curB, latB;
    logic [16:0] ref17;
    logic        refOvf;
    int          donePulses;
    @(posedge clk);
    #1;
    donePulses = 0;
    curX = 16'h0F0F;
    curY = 16'h2468;
    curB = 1'b1;
    latX = '0;
    latY = '0;
    latB = 1'b0;
    x = curX;
    y = curY;
    bin = curB;
    start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      if (k % 6 == 1) begin
        latX = curX;
        latY = curY;
        latB = curB;
      end
      checks++;
      if (done !== (k % 6 == 5)) begin
        failures++;
        $display("[TB] FAIL b2b_done_k%0d got %b need %b", k, done, (k % 6 == 5));
      end
      if (done) donePulses++;
      if (k % 6 == 5) begin
        ref17 = {1'b0, latX} - {1'b0, latY} - {16'h0, latB};
        refOvf = (latX[15] != latY[15]) && (ref17[15] != latX[15]);
        checks++;
        if ({diff, bout, overflow} !== {ref17[15:0], ref17[16], refOvf}) begin
          failures++;
          $display("[TB] FAIL b2b_result_k%0d got diff=%h bout=%b ovf=%b need %h %b %b",
                   k, diff, bout, overflow, ref17[15:0], ref17[16], refOvf);
        end
      end
      curX = curX + 16'h1357 + 16'(k);
      curY = curY ^ (16'h0123 * 16'(k));
      curB = ~curB;
      x = curX;
      y = curY;
      bin = curB;
    end
    start = 1'b0;
    checks++;
    if (donePulses !== 3) begin
      failures++;
      $display("[TB] FAIL b2b_pulse_count got %0d need 3", donePulses);
    end
  endtask

  task automatic test_async_reset();
    int edges;
    int busyCnt;
    @(posedge clk);
    #1;
    x = 16'hFFFF;
    y = 16'h0001;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || diff[3:0] !== 4'hE) begin
      failures++;
      $display("[TB] FAIL abort_pre got busy=%b diff=%h need 1 xxxe", busy, diff);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, bout, overflow} !== 19'h0) begin
      failures++;
      $display("[TB] FAIL abort_async got busy=%b done=%b diff=%h bout=%b ovf=%b need all 0",
               busy, done, diff, bout, overflow);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(16'h0010, 16'h0001, 1'b0, edges, busyCnt);
    checks++;
    if (edges !== 5 || {diff, bout, overflow} !== {16'h000F, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL after_abort got edges=%0d diff=%h bout=%b ovf=%b need 5 000f 0 0",
               edges, diff, bout, overflow);
    end
  endtask

  task automatic test_width4();
    int edges;
    @(posedge clk);
    #1;
    x4 = 4'h3;
    y4 = 4'h5;
    bin4 = 1'b0;
    start4 = 1'b1;
    edges = 0;
    while (edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
      start4 = 1'b0;
      x4 = 4'hF;
      y4 = 4'h0;
      if (done4) break;
    end
    checks++;
    if (edges !== 2 || {diff4, bout4, overflow4} !== {4'hE, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL width4 got edges=%0d diff=%h bout=%b ovf=%b need 2 e 1 0",
               edges, diff4, bout4, overflow4);
    end
  endtask

  // Run each scenario in turn, then report.
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_async_reset();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
